instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front end of the single-cycle datapath; produces the instruction stream that the control unit decodes.
- Owns the PC and fetches 32-bit words from instruction memory through a req/ack handshake.
- Holds each word in an instruction register and presents OpCode and register/immediate fields with a valid/ready handshake.
- Applies the control unit's PCWre/PCSrc decisions when an instruction retires.

Parameters:
- ADDR_W, 32: PC and memory address width.
- RESET_PC, 0: PC value after reset; must be word aligned.

Ports:
- CLK  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- PCWre  in  1  from control unit; 0 means halt (OpCode 6'b111111).
- PCSrc  in  1  from control unit; 1 means branch taken.
- ExtImm  in  32  extended immediate, word offset.
- ins_ready  in  1  datapath accepts (retires) the presented instruction.
- mem_req  out  1  instruction memory read request.
- mem_addr  out  ADDR_W  word-aligned read address.
- mem_rdata  in  32  read data; valid when mem_ack=1.
- mem_ack  in  1  read complete.
- ins_valid  out  1  instruction register holds an unretired instruction.
- OpCode  out  6  IR[31:26].
- rs  out  5  IR[25:21].
- rt  out  5  IR[20:16].
- rd  out  5  IR[15:11].
- imm16  out  16  IR[15:0].
- PC  out  ADDR_W  address of the presented instruction.
- halted  out  1  fetch stopped by a halt instruction.

Behaviour:
- Reset (asynchronous, active-high) sets all state:
  - state = IDLE, PC = RESET_PC, IR = 0.
  - mem_req = 0, ins_valid = 0, halted = 0.
  - Field outputs are therefore 0.
- States:
  - IDLE: mem_req=0. Always moves to FETCH on the next edge. This spacer cycle ensures an ack left over from before reset is never accepted.
  - FETCH:
    - mem_req=1; mem_addr=PC, held stable while in FETCH.
    - When mem_ack=1 at an edge: IR <= mem_rdata, go to HOLD.
    - mem_ack may arrive in the first FETCH cycle (single-cycle memory). That gives 1 cycle from FETCH entry to ins_valid.
  - HOLD:
    - mem_req=0, ins_valid=1. IR, PC and the field outputs are stable.
    - Retire occurs when ins_valid & ins_ready at an edge.
    - PCWre=0 at retire: go to HALT; PC unchanged.
    - PCWre=1 and PCSrc=0: PC <= PC+4, go to FETCH.
    - PCWre=1 and PCSrc=1: PC <= PC+4+(ExtImm<<2), go to FETCH.
  - HALT: halted=1, mem_req=0, ins_valid=0. Stays in HALT until Reset.
- PCWre, PCSrc and ExtImm are sampled only on the retire edge and ignored at all other times.
- Arithmetic:
  - Additions are modulo 2^ADDR_W; PC wraps from 32'hFFFFFFFC to 0 without error.
  - ExtImm<<2 is truncated to ADDR_W. A negative ExtImm (two's complement) produces a backward branch.
  - PC[1:0] is always 0.
- mem_ack is ignored in every state except FETCH.
- mem_rdata is don't-care when mem_ack=0.
- Throughput: minimum 2 cycles per instruction (FETCH with same-cycle ack, then HOLD with ins_ready=1).
- Reset asserted mid-fetch or mid-hold: the request is dropped immediately (asynchronous) and any pending instruction is discarded. Fetch restarts at RESET_PC via IDLE after Reset deasserts.

Test Plan:
- Reset release with RESET_PC=0: IDLE for 1 cycle, then mem_req=1 and mem_addr=0.
  - Ack same cycle with mem_rdata=32'h04221800 → next cycle ins_valid=1, OpCode=6'b000001, rs=1, rt=2, rd=3, PC=0.
- Sequential stream: ack after 3 wait cycles, ins_ready=1, PCWre=1, PCSrc=0 → next mem_addr=4; mem_req held with a constant address through the wait cycles.
- Taken branch: PC=8, retire with PCSrc=1, ExtImm=32'hFFFFFFFE → next mem_addr=4. With ExtImm=3 instead → next mem_addr=24.
- Backpressure: ins_ready=0 for 5 cycles → ins_valid, OpCode and PC stable, mem_req=0.
  - Toggle PCSrc during the stall; it has no effect until the retire edge.
- Halt: present OpCode 6'b111111 and retire with PCWre=0 → halted=1, ins_valid=0, mem_req=0 for 20 cycles. A stray mem_ack is ignored.
- Wrap and reset:
  - PC=32'hFFFFFFFC, retire with PCSrc=0 → mem_addr=0.
  - Separately, assert Reset while in FETCH with a stalled ack → mem_req drops in the same cycle. After release, the first request is at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: front end of the single-cycle datapath.
// Owns the PC, fetches 32-bit words through a req/ack handshake, holds each word in an
// instruction register and presents decoded fields with a valid/ready handshake. On retire
// the control unit's PCWre/PCSrc/ExtImm decide the next PC or stop fetch altogether.
//
// Ports:
//   CLK, Reset            clock, asynchronous active-high reset
//   PCWre, PCSrc, ExtImm  control-unit decisions, sampled only on the retire edge
//   ins_ready             datapath accepts (retires) the presented instruction
//   mem_req/mem_addr      instruction memory read request and word-aligned address
//   mem_rdata/mem_ack     read data and completion
//   ins_valid             instruction register holds an unretired instruction
//   OpCode/rs/rt/rd/imm16 instruction register fields
//   PC                    address of the presented instruction
//   halted                fetch stopped by a halt instruction
module instr_fetch_unit #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              PCWre,
  input  logic              PCSrc,
  input  logic [31:0]       ExtImm,
  input  logic              ins_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              ins_valid,
  output logic [5:0]        OpCode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm16,
  output logic [ADDR_W-1:0] PC,
  output logic              halted
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;
  localparam logic [1:0] StHalt  = 2'd3;

  // Low PC bits are forced to zero so the PC can never become misaligned.
  localparam logic [ADDR_W-1:0] ResetPcAligned = {RESET_PC[ADDR_W-1:2], 2'b00};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] br_off;
  logic              retire;

  // Sign-extend the word offset before scaling so negative offsets branch backwards for any
  // ADDR_W; the sum is truncated to ADDR_W, giving modulo-2^ADDR_W arithmetic.
  assign br_off   = ADDR_W'({{ADDR_W{ExtImm[31]}}, ExtImm, 2'b00});
  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign retire   = (state_q == StHold) && ins_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      // Spacer cycle: an ack left over from before reset is never seen in FETCH.
      StIdle: state_d = StFetch;
      StFetch: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = StHold;
        end
      end
      StHold: begin
        if (retire) begin
          if (!PCWre) begin
            state_d = StHalt;
          end else begin
            pc_d    = PCSrc ? (pc_plus4 + br_off) : pc_plus4;
            state_d = StFetch;
          end
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      pc_q    <= ResetPcAligned;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= {pc_d[ADDR_W-1:2], 2'b00};
      ir_q    <= ir_d;
    end
  end

  // Outputs decode directly from state so an asynchronous reset drops mem_req immediately.
  assign mem_req   = (state_q == StFetch);
  assign ins_valid = (state_q == StHold);
  assign halted    = (state_q == StHalt);
  assign mem_addr  = pc_q;
  assign PC        = pc_q;

  assign OpCode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign imm16  = ir_q[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        PCWre;
  logic        PCSrc;
  logic [31:0] ExtImm;
  logic        ins_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        ins_valid;
  logic [5:0]  OpCode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic [31:0] PC;
  logic        halted;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(
    .ADDR_W  (32),
    .RESET_PC(32'h0)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .PCWre    (PCWre),
    .PCSrc    (PCSrc),
    .ExtImm   (ExtImm),
    .ins_ready(ins_ready),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .ins_valid(ins_valid),
    .OpCode   (OpCode),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .imm16    (imm16),
    .PC       (PC),
    .halted   (halted)
  );

  always #5 CLK = ~CLK;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // From HOLD: retire with the given controls, leaving the DUT in FETCH.
  task automatic retire(input logic wre, input logic src, input logic [31:0] imm);
    PCWre = wre; PCSrc = src; ExtImm = imm; ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0; PCSrc = 1'b0; ExtImm = 32'h0;
  endtask

  // From FETCH: single-cycle ack with the given word, leaving the DUT in HOLD.
  task automatic fetch_now(input logic [31:0] word);
    mem_ack = 1'b1; mem_rdata = word;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(); tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", mem_req); end
    total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ins_valid); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", halted); end
    total++; if (OpCode !== 6'd0 || imm16 !== 16'd0) begin
      bad++; $display("FAIL rst_fields got=%h/%h exp=0/0", OpCode, imm16); end
    total++; if (PC !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", PC); end
    Reset = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%b exp=0", mem_req); end
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      bad++; $display("FAIL first_fetch got=%b/%h exp=1/0", mem_req, mem_addr); end
    fetch_now(32'h0422_1800);
    total++; if (ins_valid !== 1'b1 || mem_req !== 1'b0) begin
      bad++; $display("FAIL first_hold got=%b/%b exp=1/0", ins_valid, mem_req); end
    total++; if (OpCode !== 6'd1 || rs !== 5'd1 || rt !== 5'd2 || rd !== 5'd3) begin
      bad++; $display("FAIL first_fields got=%0d/%0d/%0d/%0d exp=1/1/2/3", OpCode, rs, rt, rd); end
    total++; if (imm16 !== 16'h1800 || PC !== 32'h0) begin
      bad++; $display("FAIL first_imm_pc got=%h/%h exp=1800/0", imm16, PC); end
  endtask

  task automatic test_sequential();
    retire(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      total++; if (mem_req !== 1'b1 || mem_addr !== 32'h4 || ins_valid !== 1'b0) begin
        bad++; $display("FAIL seq_wait%0d got=%b/%h exp=1/4", i, mem_req, mem_addr); end
      tick();
    end
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
      bad++; $display("FAIL seq_wait3 got=%b/%h exp=1/4", mem_req, mem_addr); end
    fetch_now(32'h0000_0000);
    total++; if (ins_valid !== 1'b1 || PC !== 32'h4) begin
      bad++; $display("FAIL seq_hold got=%b/%h exp=1/4", ins_valid, PC); end
  endtask

  task automatic test_branch();
    retire(1'b1, 1'b0, 32'h0);
    fetch_now(32'h1000_0000);
    total++; if (PC !== 32'h8) begin bad++; $display("FAIL br_setup got=%h exp=8", PC); end
    retire(1'b1, 1'b1, 32'hFFFF_FFFE);
    total++; if (mem_addr !== 32'h4) begin bad++; $display("FAIL br_back got=%h exp=4", mem_addr); end
    fetch_now(32'h0);
    retire(1'b1, 1'b0, 32'h0);
    fetch_now(32'h1000_0003);
    retire(1'b1, 1'b1, 32'h3);
    total++; if (mem_addr !== 32'd24) begin bad++; $display("FAIL br_fwd got=%h exp=18", mem_addr); end
  endtask

  task automatic test_backpressure();
    fetch_now(32'h8C41_0008);
    for (int i = 0; i < 5; i++) begin
      PCSrc = ~PCSrc; PCWre = i[0]; ExtImm = 32'd100 + 32'(i);
      tick();
      total++; if (ins_valid !== 1'b1 || mem_req !== 1'b0 || OpCode !== 6'd35 || PC !== 32'd24) begin
        bad++; $display("FAIL stall%0d got=%b/%b/%0d/%h exp=1/0/35/18", i, ins_valid, mem_req,
                        OpCode, PC); end
    end
    retire(1'b1, 1'b0, 32'd100);
    total++; if (mem_addr !== 32'd28 || mem_req !== 1'b1) begin
      bad++; $display("FAIL stall_retire got=%h/%b exp=1c/1", mem_addr, mem_req); end
  endtask

  task automatic test_halt();
    fetch_now(32'hFC00_0000);
    total++; if (OpCode !== 6'h3F) begin bad++; $display("FAIL halt_op got=%h exp=3f", OpCode); end
    retire(1'b0, 1'b1, 32'h5);
    for (int i = 0; i < 20; i++) begin
      total++; if (halted !== 1'b1 || ins_valid !== 1'b0 || mem_req !== 1'b0 || PC !== 32'd28) begin
        bad++; $display("FAIL halt%0d got=%b/%b/%b/%h exp=1/0/0/1c", i, halted, ins_valid, mem_req,
                        PC); end
      mem_ack = (i % 3 == 0); mem_rdata = 32'h0422_1800; ins_ready = 1'b1; PCWre = 1'b1;
      tick();
    end
    mem_ack = 1'b0; ins_ready = 1'b0;
    total++; if (halted !== 1'b1 || OpCode !== 6'h3F) begin
      bad++; $display("FAIL halt_end got=%b/%h exp=1/3f", halted, OpCode); end
  endtask

  task automatic test_wrap_reset();
    Reset = 1'b1; #1; Reset = 1'b0;
    tick(); // IDLE -> FETCH
    fetch_now(32'h0);
    retire(1'b1, 1'b1, 32'hFFFF_FFFE);
    total++; if (mem_addr !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_setup got=%h exp=fffffffc", mem_addr); end
    fetch_now(32'h0);
    retire(1'b1, 1'b0, 32'h0);
    total++; if (mem_addr !== 32'h0 || mem_req !== 1'b1) begin
      bad++; $display("FAIL wrap got=%h/%b exp=0/1", mem_addr, mem_req); end
    retire(1'b1, 1'b0, 32'h0); // ins_ready in FETCH must be ignored
    fetch_now(32'h0);
    retire(1'b1, 1'b0, 32'h0);
    tick(); // stalled ack, now at address 4
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
      bad++; $display("FAIL midfetch_setup got=%b/%h exp=1/4", mem_req, mem_addr); end
    #2; Reset = 1'b1; #1;
    total++; if (mem_req !== 1'b0 || PC !== 32'h0) begin
      bad++; $display("FAIL async_drop got=%b/%h exp=0/0", mem_req, PC); end
    mem_ack = 1'b1; mem_rdata = 32'hFC00_0000; // stale ack across reset release
    tick();
    Reset = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0 || ins_valid !== 1'b0) begin
      bad++; $display("FAIL post_idle got=%b/%b exp=0/0", mem_req, ins_valid); end
    mem_ack = 1'b0;
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || ins_valid !== 1'b0) begin
      bad++; $display("FAIL post_fetch got=%b/%h/%b exp=1/0/0", mem_req, mem_addr, ins_valid); end
  endtask

  initial begin
    Reset = 1'b1; PCWre = 1'b1; PCSrc = 1'b0; ExtImm = 32'h0; ins_ready = 1'b0;
    mem_rdata = 32'h0; mem_ack = 1'b0;
    test_reset();
    test_sequential();
    test_branch();
    test_backpressure();
    test_halt();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
